nibble_adder_arbiter: RTL and testbench

- Shares one 4-bit ripple-carry adder datapath between two requesters.
- Each request is a W-bit add, W = 4*NIBBLES, executed serially one nibble per cycle with a registered carry.
- Per-requester operand buffers, round-robin arbitration, single shared result bus tagged with requester id.
- Sits between the two requesting datapaths and the adder.

---
 rtl/nibble_adder_arbiter_if.sv | 29 ++
 rtl/nibble_adder_arbiter.sv | 171 +++++++++++++++++
 tb/tb_nibble_adder_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/nibble_adder_arbiter_if.sv
// Request/result bus between the two requesting datapaths and the shared serial adder.
// Index [n] of each packed pair belongs to requester n. NIBBLE_ADDER_SUB_EN adds the sub inputs.
interface nibble_adder_arbiter_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic [1:0]          req;
   logic [1:0][W-1:0]   a;
   logic [1:0][W-1:0]   b;
   logic [1:0]          cin;
   logic [1:0]          busy;
`ifdef NIBBLE_ADDER_SUB_EN
   logic [1:0]          sub;
`endif
   logic                done;
   logic                done_id;
   logic [W-1:0]        sum;
   logic                cout;
   logic                ovf;

`ifdef NIBBLE_ADDER_SUB_EN
   modport master (output req, a, b, cin, sub, input busy, done, done_id, sum, cout, ovf);
   modport slave  (input req, a, b, cin, sub, output busy, done, done_id, sum, cout, ovf);
`else
   modport master (output req, a, b, cin, input busy, done, done_id, sum, cout, ovf);
   modport slave  (input req, a, b, cin, output busy, done, done_id, sum, cout, ovf);
`endif
endinterface

// File: rtl/nibble_adder_arbiter.sv
// Two requesters share one 4-bit adder; each W-bit add runs one nibble per cycle.
// Optional subtract mode is enabled with NIBBLE_ADDER_SUB_EN.
module nibble_adder_arbiter #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   nibble_adder_arbiter_if.slave  bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [1:0]        busy_q, busy_d;
   logic [1:0]        wait_q, wait_d;
   logic [1:0][W-1:0] bufa_q, bufa_d;
   logic [1:0][W-1:0] bufb_q, bufb_d;
   logic [1:0]        bufc_q, bufc_d;
   logic [1:0]        bufs_q, bufs_d;
   logic              last_q, last_d;
   logic              gnt_q, gnt_d;
   logic [W-1:0]      a_q, a_d, b_q, b_d, res_q, res_d;
   logic              carry_q, carry_d;
   logic              amsb_q, amsb_d, bmsb_q, bmsb_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              done_q, done_d, id_q, id_d;
   logic [W-1:0]      sum_q, sum_d;
   logic              cout_q, cout_d, ovf_q, ovf_d;

   logic [1:0]        cap, sub_in;
   logic              sel;
   logic [4:0]        nib;
   logic [W+3:0]      shifted;

`ifdef NIBBLE_ADDER_SUB_EN
   assign sub_in = bus.sub;
`else
   assign sub_in = 2'b00;
`endif

   assign cap = bus.req & ~busy_q;
   // The pointer only moves on a contested grant, so an uncontested grant never steals the next tie.
   assign sel = (&wait_q) ? ~last_q : wait_q[1];
   assign nib = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, carry_q};
   assign shifted = {nib[3:0], res_q};

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q | cap;
      wait_d  = wait_q | cap;
      bufa_d  = bufa_q;
      bufb_d  = bufb_q;
      bufc_d  = bufc_q;
      bufs_d  = bufs_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      amsb_d  = amsb_q;
      bmsb_d  = bmsb_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      id_d    = id_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      for (int n = 0; n < 2; n++) begin
         if (cap[n]) begin
            bufa_d[n] = bus.a[n];
            bufb_d[n] = bus.b[n];
            bufc_d[n] = bus.cin[n];
            bufs_d[n] = sub_in[n];
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (|wait_q) begin
               state_d     = S_ADD;
               gnt_d       = sel;
               wait_d[sel] = 1'b0;
               if (&wait_q) last_d = sel;
               a_d     = bufa_q[sel];
               b_d     = bufs_q[sel] ? ~bufb_q[sel] : bufb_q[sel];
               carry_d = bufs_q[sel] ? 1'b1 : bufc_q[sel];
               amsb_d  = a_d[W-1];
               bmsb_d  = b_d[W-1];
               idx_d   = '0;
            end
         end
         S_ADD: begin
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            carry_d = nib[4];
            res_d   = shifted[W+3:4];
            idx_d   = idx_q + 1'b1;
            if (idx_q == IW'(NIBBLES - 1)) begin
               state_d       = S_DONE;
               done_d        = 1'b1;
               id_d          = gnt_q;
               sum_d         = shifted[W+3:4];
               cout_d        = nib[4];
               ovf_d         = (amsb_q == bmsb_q) && (nib[3] != amsb_q);
               busy_d[gnt_q] = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         busy_q  <= '0;
         wait_q  <= '0;
         bufa_q  <= '0;
         bufb_q  <= '0;
         bufc_q  <= '0;
         bufs_q  <= '0;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         amsb_q  <= 1'b0;
         bmsb_q  <= 1'b0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         id_q    <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         wait_q  <= wait_d;
         bufa_q  <= bufa_d;
         bufb_q  <= bufb_d;
         bufc_q  <= bufc_d;
         bufs_q  <= bufs_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         amsb_q  <= amsb_d;
         bmsb_q  <= bmsb_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         id_q    <= id_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.done_id = id_q;
   assign bus.sum     = sum_q;
   assign bus.cout    = cout_q;
   assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_nibble_adder_arbiter.sv
// Scoreboard bench for nibble_adder_arbiter (NIBBLES=4); subtract cases run when NIBBLE_ADDER_SUB_EN is defined.
module tb_nibble_adder_arbiter;
   localparam int NIBBLES = 4;
   localparam int W = 4 * NIBBLES;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   typedef struct {
      logic         id;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           cyc;
   } exp_t;

   exp_t sb[$];

   nibble_adder_arbiter_if #(.NIBBLES(NIBBLES)) bus ();
   nibble_adder_arbiter #(.NIBBLES(NIBBLES)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub, input int at);
      exp_t         e;
      logic [W-1:0] bb;
      logic [W:0]   full;
      bb     = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
      e.id   = id;
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
      e.cyc  = at;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_id", {31'd0, bus.done_id}, {31'd0, e.id});
            chk("sum", {16'd0, bus.sum}, {16'd0, e.sum});
            chk("cout", {31'd0, bus.cout}, {31'd0, e.cout});
            chk("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
            chk("latency", cyc, e.cyc);
         end
      end
   end

   task automatic drive(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
      bus.req[id] = 1'b1;
      bus.a[id]   = a;
      bus.b[id]   = b;
      bus.cin[id] = cin;
`ifdef NIBBLE_ADDER_SUB_EN
      bus.sub[id] = sub;
`endif
   endtask

   task automatic release_reqs();
      bus.req = 2'b00;
`ifdef NIBBLE_ADDER_SUB_EN
      bus.sub = 2'b00;
`endif
   endtask

   // Single request from an idle block; done expected 5 edges after the sampling edge.
   task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input bit push);
      @(negedge clk);
      drive(id, a, b, cin, sub);
      if (push) sb.push_back(model(id, a, b, cin, sub, cyc + 1 + NIBBLES + 1));
      @(negedge clk);
      release_reqs();
   endtask

   task automatic pair(input logic first, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1);
      int l0, l1;
      @(negedge clk);
      drive(1'b0, a0, b0, 1'b0, 1'b0);
      drive(1'b1, a1, b1, 1'b0, 1'b0);
      l0 = cyc + 1 + NIBBLES + 1 + (first ? NIBBLES + 1 : 0);
      l1 = cyc + 1 + NIBBLES + 1 + (first ? 0 : NIBBLES + 1);
      if (first) begin
         sb.push_back(model(1'b1, a1, b1, 1'b0, 1'b0, l1));
         sb.push_back(model(1'b0, a0, b0, 1'b0, 1'b0, l0));
      end else begin
         sb.push_back(model(1'b0, a0, b0, 1'b0, 1'b0, l0));
         sb.push_back(model(1'b1, a1, b1, 1'b0, 1'b0, l1));
      end
      @(negedge clk);
      release_reqs();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("drain_timeout", {31'd0, (sb.size() != 0)}, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bus.req = 2'b00;
      bus.a   = '0;
      bus.b   = '0;
      bus.cin = 2'b00;
`ifdef NIBBLE_ADDER_SUB_EN
      bus.sub = 2'b00;
`endif
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_busy", {30'd0, bus.busy}, 32'd0);
      chk("rst_sum", {16'd0, bus.sum}, 32'd0);
      chk("rst_cout_ovf_id", {29'd0, bus.cout, bus.ovf, bus.done_id}, 32'd0);

      // Basic add with busy window of NIBBLES+1 cycles
      issue(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k <= NIBBLES + 1; k++) begin
         chk("busy0_window", {31'd0, bus.busy[0]}, {31'd0, (k <= NIBBLES)});
         @(negedge clk);
      end
      drain();

      issue(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      drain();
      issue(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      drain();
      chk("hold_sum", {16'd0, bus.sum}, 32'h8000);

      // Ties: fresh pointer favours 0, then the next tie goes to 1
      do_reset();
      pair(1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      drain();
      pair(1'b1, 16'hF0F0, 16'h0F0F, 16'h8000, 16'h8000);
      drain();

      // Re-request while busy is ignored
      issue(1'b0, 16'h1234, 16'h1111, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
      @(negedge clk);
      release_reqs();
      drain();

      for (int i = 0; i < 4; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = W'($urandom);
         issue(i[0], ra, rb, $urandom_range(1, 0) == 1, 1'b0, 1'b1);
         drain();
      end

      // Reset during the second ADD cycle aborts silently
      issue(1'b0, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {30'd0, bus.busy}, 32'd0);
      chk("abort_sum", {16'd0, bus.sum}, 32'd0);
      chk("abort_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
      repeat (10) @(negedge clk);

`ifdef NIBBLE_ADDER_SUB_EN
      issue(1'b0, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
      drain();
      issue(1'b0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
      drain();
`endif

      chk("sb_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
